// File: rtl/fir_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_regs_pkg
// Purpose  : Register map, response codes and FSM state types for the
//            FIR coefficient register file.
// Revision : 1.0 - initial release
// ============================================================================
package fir_regs_pkg;

    localparam logic [31:0] CTRL_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;
    localparam logic [31:0] SHADOW_BASE   = 32'h0000_0100;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_bank
// Purpose  : Double-buffered coefficient storage: shadow bank written by
//            software, active bank copied from shadow on commit.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 128,
    parameter int IDX_WIDTH  = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [IDX_WIDTH-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH-1:0]        wr_mask,
    input  logic [IDX_WIDTH-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         commit,
    output logic signed [DATA_WIDTH-1:0] coeff [TAPS],
    output logic                         coeff_update,
    output logic                         pending
);

    logic [DATA_WIDTH-1:0] r_shadow [TAPS];

    assign rd_data = r_shadow[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_shadow[k] <= '0;
                coeff[k]    <= '0;
            end
            coeff_update <= 1'b0;
            pending      <= 1'b0;
        end else begin
            // The pulse coincides with the first cycle the copied bank is visible.
            coeff_update <= commit;
            if (commit) begin
                for (int k = 0; k < TAPS; k++) begin
                    coeff[k] <= r_shadow[k];
                end
                pending <= 1'b0;
            end else if (wr_en) begin
                r_shadow[wr_idx] <= (r_shadow[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
                pending          <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_regfile
// Purpose  : AXI4-Lite slave front end (write/read FSMs, address decode) for
//            the double-buffered FIR coefficient bank.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_regfile
    import fir_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 128,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [31:0]                  s_wdata,
    input  logic [3:0]                   s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [ADDR_WIDTH-1:0]        s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [31:0]                  s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic signed [DATA_WIDTH-1:0] coeff [TAPS],
    output logic                         coeff_update
);

    localparam int          IDX_WIDTH  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [31:0] SHADOW_END = SHADOW_BASE + 32'(4 * TAPS);

    function automatic logic is_shadow(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (32'(addr) >= SHADOW_BASE) && (32'(addr) < SHADOW_END);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] shadow_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'((32'(addr) - SHADOW_BASE) >> 2);
    endfunction

    // ---------------- write channel ----------------
    wr_state_t               r_wr_state, w_wr_state_nxt;
    logic                    r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic [1:0]              r_bresp;
    logic                    r_commit;
    logic                    w_wr_fire;
    logic                    w_wr_shadow, w_wr_ctrl, w_wr_status;
    logic [DATA_WIDTH-1:0]   w_wr_mask;
    logic                    w_unused_bits;

    assign w_wr_shadow   = is_shadow(r_awaddr);
    assign w_wr_ctrl     = (32'(r_awaddr) == CTRL_OFFSET);
    assign w_wr_status   = (32'(r_awaddr) == STATUS_OFFSET);
    assign w_unused_bits = ^{r_wdata, r_wstrb};

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_wr_mask
        assign w_wr_mask[i] = r_wstrb[i / 8];
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        s_awready      = 1'b0;
        s_wready       = 1'b0;
        s_bvalid       = 1'b0;
        w_wr_fire      = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                s_awready = !r_aw_held;
                s_wready  = !r_w_held;
                if (r_aw_held && r_w_held) begin
                    w_wr_fire      = 1'b1;
                    w_wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= w_wr_fire && w_wr_ctrl && r_wstrb[0] && r_wdata[0];
            if (s_awvalid && s_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_wr_fire) begin
                // STATUS is a mapped read-only register: writes are dropped but acknowledged.
                r_bresp <= (w_wr_shadow || w_wr_ctrl || w_wr_status) ? RESP_OKAY : RESP_SLVERR;
            end
            if (s_bvalid && s_bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    assign s_bresp = r_bresp;

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic [31:0]           w_rd_value;
    logic [1:0]            w_rd_resp;
    logic [DATA_WIDTH-1:0] w_rd_shadow;
    logic                  w_pending;

    always_comb begin
        w_rd_value = '0;
        w_rd_resp  = RESP_OKAY;
        if (32'(s_araddr) == CTRL_OFFSET) begin
            w_rd_value = '0;
        end else if (32'(s_araddr) == STATUS_OFFSET) begin
            w_rd_value = {31'b0, w_pending};
        end else if (is_shadow(s_araddr)) begin
            w_rd_value = 32'($signed(w_rd_shadow));
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        s_arready      = 1'b0;
        s_rvalid       = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    w_rd_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (s_arvalid && s_arready) begin
                r_rdata <= w_rd_value;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign s_rdata = r_rdata;
    assign s_rresp = r_rresp;

    fir_coeff_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAPS       (TAPS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (w_wr_fire && w_wr_shadow),
        .wr_idx       (shadow_idx(r_awaddr)),
        .wr_data      (r_wdata[DATA_WIDTH-1:0]),
        .wr_mask      (w_wr_mask),
        .rd_idx       (shadow_idx(s_araddr)),
        .rd_data      (w_rd_shadow),
        .commit       (r_commit),
        .coeff        (coeff),
        .coeff_update (coeff_update),
        .pending      (w_pending)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_regfile
// Purpose  : Directed, table-driven self-checking bench for fir_coeff_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_regfile;
    import fir_regs_pkg::*;

    localparam int DW = 16;
    localparam int NT = 128;
    localparam int AW = 12;
    localparam int NV = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AW-1:0]        s_awaddr, s_araddr;
    logic                 s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0]          s_wdata, s_rdata;
    logic [3:0]           s_wstrb;
    logic [1:0]           s_bresp, s_rresp;
    logic                 s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic signed [DW-1:0] coeff [NT];
    logic                 coeff_update;

    fir_coeff_regfile #(.DATA_WIDTH(DW), .TAPS(NT), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .coeff(coeff), .coeff_update(coeff_update)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    always @(negedge clk) if (coeff_update === 1'b1) upd_cnt++;

    typedef struct {
        bit          is_wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the B handshake.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit aw_ok, w_ok, aw_fire, w_fire;
        int t;
        aw_ok = 0; w_ok = 0; t = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        while (!(aw_ok && w_ok) && t < 64) begin
            s_awvalid = !aw_ok && (t >= aw_dly);
            s_wvalid  = !w_ok && (t >= w_dly);
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            @(negedge clk);
            t++;
            aw_ok = aw_ok | aw_fire;
            w_ok  = w_ok | w_fire;
            if (aw_ok != w_ok)
                chk("held_ready", {30'b0, s_awready, s_wready}, {30'b0, !aw_ok, !w_ok});
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("aw_w_accepted", {31'b0, aw_ok && w_ok}, 32'd1);
        t = 0;
        while (!s_bvalid && t < 16) begin
            @(negedge clk);
            t++;
        end
        chk("bvalid_latency", t, 32'd1);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            chk("bvalid_held", {31'b0, s_bvalid}, 32'd1);
        end
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk("bvalid_clear", {31'b0, s_bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        int t;
        t = 0;
        s_araddr  = a;
        s_arvalid = 1'b1;
        while (!s_arready && t < 16) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("rvalid_latency", {31'b0, s_rvalid}, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("rdata_stable", {s_rdata[30:0], s_rvalid}, {data[30:0], 1'b1});
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk("rvalid_clear", {31'b0, s_rvalid}, 32'd0);
    endtask

    function automatic int count_nonzero_coeff();
        int n;
        n = 0;
        for (int k = 0; k < NT; k++) if (coeff[k] !== '0) n++;
        return n;
    endfunction

    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          upd_before;

    initial begin
        vecs[0]  = '{1'b1, 12'h104, 32'hFFFF_8001, 4'hF, RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 12'h104, 32'h0,         4'h0, RESP_OKAY,   32'hFFFF_8001};
        vecs[2]  = '{1'b0, 12'h004, 32'h0,         4'h0, RESP_OKAY,   32'h1};
        vecs[3]  = '{1'b1, 12'h108, 32'h0000_1234, 4'hF, RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b0, 12'h108, 32'h0,         4'h0, RESP_OKAY,   32'h0000_1234};
        vecs[5]  = '{1'b1, 12'h108, 32'h0000_00AB, 4'h1, RESP_OKAY,   32'h0};
        vecs[6]  = '{1'b0, 12'h108, 32'h0,         4'h0, RESP_OKAY,   32'h0000_12AB};
        vecs[7]  = '{1'b1, 12'h400, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 32'h0};
        vecs[8]  = '{1'b0, 12'h008, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[9]  = '{1'b0, 12'h400, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[10] = '{1'b0, 12'h000, 32'h0,         4'h0, RESP_OKAY,   32'h0};
        vecs[11] = '{1'b1, 12'h2FC, 32'h0001_7FFF, 4'hF, RESP_OKAY,   32'h0};
        vecs[12] = '{1'b0, 12'h2FC, 32'h0,         4'h0, RESP_OKAY,   32'h0000_7FFF};
        vecs[13] = '{1'b1, 12'h10C, 32'h0000_ABCD, 4'h2, RESP_OKAY,   32'h0};
        vecs[14] = '{1'b0, 12'h10C, 32'h0,         4'h0, RESP_OKAY,   32'hFFFF_AB00};

        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_readies", {29'b0, s_awready, s_wready, s_arready}, 32'h7);
        chk("reset_valids", {29'b0, s_bvalid, s_rvalid, coeff_update}, 32'h0);
        chk("reset_coeff_nonzero", count_nonzero_coeff(), 32'd0);

        for (int k = 0; k < NT; k++) begin
            do_read(AW'(12'h100 + 4 * k), 0, rd, rr);
            chk($sformatf("init_shadow%0d", k), {rr, rd[29:0]}, {RESP_OKAY, 30'h0});
            chk($sformatf("init_shadow%0d_hi", k), {30'b0, rd[31:30]}, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, br);
                chk($sformatf("vec%0d_bresp", i), {30'b0, br}, {30'b0, vecs[i].exp_resp});
            end else begin
                do_read(vecs[i].addr, 0, rd, rr);
                chk($sformatf("vec%0d_rresp", i), {30'b0, rr}, {30'b0, vecs[i].exp_resp});
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        chk("coeff1_before_commit", 32'(coeff[1]), 32'h0);
        chk("no_update_before_commit", upd_cnt, 32'd0);

        do_write(12'h000, 32'h1, 4'hF, 0, 0, 0, br);
        chk("commit_bresp", {30'b0, br}, {30'b0, RESP_OKAY});
        repeat (2) @(negedge clk);
        chk("coeff1_committed", 32'(coeff[1]), 32'(-32767));
        chk("coeff2_committed", 32'(coeff[2]), 32'h0000_12AB);
        chk("coeff3_committed", 32'(coeff[3]), 32'(-21760));
        chk("coeff127_committed", 32'(coeff[127]), 32'h0000_7FFF);
        chk("update_pulses", upd_cnt, 32'd1);
        do_read(12'h004, 0, rd, rr);
        chk("status_after_commit", rd, 32'h0);
        do_read(12'h000, 0, rd, rr);
        chk("ctrl_reads_zero", rd, 32'h0);

        do_write(12'h400, 32'h0000_FFFF, 4'hF, 0, 0, 0, br);
        chk("oob_write_slverr", {30'b0, br}, {30'b0, RESP_SLVERR});
        do_read(12'h004, 0, rd, rr);
        chk("oob_status_unchanged", rd, 32'h0);
        chk("oob_coeff_unchanged", 32'(coeff[1]), 32'(-32767));

        // W leads AW, then AW leads W, with a stalled response on the first.
        do_write(12'h110, 32'h0000_1111, 4'hF, 3, 0, 5, br);
        chk("w_first_bresp", {30'b0, br}, {30'b0, RESP_OKAY});
        do_write(12'h114, 32'h0000_2222, 4'hF, 0, 2, 0, br);
        chk("aw_first_bresp", {30'b0, br}, {30'b0, RESP_OKAY});
        do_read(12'h110, 3, rd, rr);
        chk("w_first_data", rd, 32'h0000_1111);
        do_read(12'h114, 0, rd, rr);
        chk("aw_first_data", rd, 32'h0000_2222);
        do_read(12'h004, 0, rd, rr);
        chk("status_pending", rd, 32'h1);
        chk("coeff4_uncommitted", 32'(coeff[4]), 32'h0);
        chk("update_pulses_stable", upd_cnt, 32'd1);

        // Reset while a commit write's response is outstanding.
        upd_before = upd_cnt;
        s_awaddr = '0; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_before_reset", {31'b0, s_bvalid}, 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_drops_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("reset_clears_coeff", count_nonzero_coeff(), 32'd0);
        chk("reset_no_update", upd_cnt, upd_before);
        do_read(12'h110, 0, rd, rr);
        chk("reset_clears_shadow", rd, 32'h0);
        do_read(12'h004, 0, rd, rr);
        chk("reset_clears_pending", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
